// File: rtl/rb_arbiter_pkg.sv
// Shared constants for the two-port register-bank arbiter: bank geometry, RW encoding, FSM states.
package rb_arb_pkg;
  localparam int RB_AW = 3;
  localparam int RB_DW = 18;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t ACC  = 2'd1;
  localparam state_t DONE = 2'd2;
endpackage

// File: rtl/rb_arbiter_rr_arb2.sv
// Two-way combinational picker: one-hot winner among eligible ports, zero latency.
// Ties go to the port that did not win last, or always to port 0 when fixed_prio is set.
module rr_arb2 (
  input  logic [1:0] eligible,
  input  logic       last,
  input  logic       fixed_prio,
  output logic [1:0] win
);
  always_comb begin
    win = eligible;
    if (eligible == 2'b11) begin
      win = (fixed_prio || last) ? 2'b01 : 2'b10;
    end
  end
endmodule

// File: rtl/rb_arbiter.sv
// Serialises two requesters onto one register bank: grant/bus at N+1, read data at N+2; requesters hold req until gnt.
// Tracks written addresses and pulses all_wr once the map fills; RB_ARB_FIXED_PRIO_EN makes port 0 win every conflict.
module rb_arbiter
  import rb_arb_pkg::*;
#(
  parameter int AW = RB_AW,
  parameter int DW = RB_DW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             rw0,
  input  logic [AW-1:0]    a0,
  input  logic [DW-1:0]    d0,
  output logic             gnt0,
  output logic [DW-1:0]    q0,
  output logic             vld0,
  input  logic             req1,
  input  logic             rw1,
  input  logic [AW-1:0]    a1,
  input  logic [DW-1:0]    d1,
  output logic             gnt1,
  output logic [DW-1:0]    q1,
  output logic             vld1,
  output logic             RB_RW,
  output logic [AW-1:0]    RB_A,
  output logic [DW-1:0]    RB_D,
  input  logic [DW-1:0]    RB_Q,
  output logic [2**AW-1:0] wr_map,
  output logic             all_wr
);

`ifdef RB_ARB_FIXED_PRIO_EN
  localparam logic FIXED_PRIO = 1'b1;
`else
  localparam logic FIXED_PRIO = 1'b0;
`endif

  state_t     state;
  logic       last;
  logic       map_full_q;
  logic [1:0] mask;
  logic [1:0] eligible;
  logic [1:0] win;

  // In DONE the port granted last is still finishing its handshake, so it cannot win again yet.
  assign mask     = (state == DONE) ? {last, ~last} : 2'b00;
  assign eligible = {req1, req0} & ~mask;

  rr_arb2 u_pick (
    .eligible   (eligible),
    .last       (last),
    .fixed_prio (FIXED_PRIO),
    .win        (win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      RB_RW <= RW_READ;
      RB_A  <= '0;
      RB_D  <= '0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      vld0  <= 1'b0;
      vld1  <= 1'b0;
      q0    <= '0;
      q1    <= '0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      vld0 <= 1'b0;
      vld1 <= 1'b0;
      case (state)
        ACC: begin
          // gnt0/gnt1 are high exactly during ACC and name the port being served.
          if (RB_RW == RW_READ) begin
            if (gnt0) begin
              q0   <= RB_Q;
              vld0 <= 1'b1;
            end
            if (gnt1) begin
              q1   <= RB_Q;
              vld1 <= 1'b1;
            end
          end
          RB_RW <= RW_READ;
          state <= DONE;
        end
        default: begin
          RB_RW <= RW_READ;
          state <= IDLE;
          if (win[0]) begin
            RB_RW <= rw0;
            RB_A  <= a0;
            RB_D  <= d0;
            gnt0  <= 1'b1;
            last  <= 1'b0;
            state <= ACC;
          end else if (win[1]) begin
            RB_RW <= rw1;
            RB_A  <= a1;
            RB_D  <= d1;
            gnt1  <= 1'b1;
            last  <= 1'b1;
            state <= ACC;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_map     <= '0;
      map_full_q <= 1'b0;
      all_wr     <= 1'b0;
    end else begin
      if (state == ACC && RB_RW == RW_WRITE) begin
        wr_map[RB_A] <= 1'b1;
      end
      map_full_q <= &wr_map;
      all_wr     <= (&wr_map) & ~map_full_q;
    end
  end
endmodule

// File: tb/tb_rb_arbiter.sv
// Directed bench for rb_arbiter: an attached 8x18 bank plus a grant-history model checked every cycle.
module tb_rb_arbiter;
`ifdef RB_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0 = 1'b0, rw0 = 1'b1, req1 = 1'b0, rw1 = 1'b1;
  logic [2:0]  a0 = '0, a1 = '0;
  logic [17:0] d0 = '0, d1 = '0;
  logic        gnt0, vld0, gnt1, vld1, RB_RW, all_wr;
  logic [17:0] q0, q1, RB_D, RB_Q;
  logic [2:0]  RB_A;
  logic [7:0]  wr_map;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int all_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  rb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .rw0(rw0), .a0(a0), .d0(d0), .gnt0(gnt0), .q0(q0), .vld0(vld0),
    .req1(req1), .rw1(rw1), .a1(a1), .d1(d1), .gnt1(gnt1), .q1(q1), .vld1(vld1),
    .RB_RW(RB_RW), .RB_A(RB_A), .RB_D(RB_D), .RB_Q(RB_Q),
    .wr_map(wr_map), .all_wr(all_wr)
  );

  // The bank itself: combinational read, write on the rising edge when RB_RW = 0.
  logic [17:0] bank [8] = '{18'h01000, 18'h01001, 18'h01002, 18'h01003,
                            18'h01004, 18'h01005, 18'h01006, 18'h01007};
  assign RB_Q = bank[RB_A];
  always @(posedge clk) if (RB_RW == 1'b0) bank[RB_A] <= RB_D;

  // Model: which port was granted one and two cycles ago decides the present cycle.
  int          m_prev = -1, m_prev2 = -1, m_last = 1, m_now = -1;
  bit          el0, el1;
  logic        m_prev_rw = 1'b1;
  logic [2:0]  m_prev_a = '0;
  logic [17:0] m_prev_d = '0;
  logic [17:0] m_mem [8] = '{18'h01000, 18'h01001, 18'h01002, 18'h01003,
                             18'h01004, 18'h01005, 18'h01006, 18'h01007};
  logic [7:0]  m_map = '0;
  logic        m_just_full = 1'b0;
  logic        e_gnt0 = 0, e_gnt1 = 0, e_vld0 = 0, e_vld1 = 0, e_rw = 1, e_all = 0;
  logic [2:0]  e_a = '0;
  logic [17:0] e_d = '0, e_q0 = '0, e_q1 = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev = -1; m_prev2 = -1; m_last = 1; m_map = '0; m_just_full = 1'b0;
      e_gnt0 = 0; e_gnt1 = 0; e_vld0 = 0; e_vld1 = 0; e_rw = 1; e_all = 0;
      e_a = '0; e_d = '0; e_q0 = '0; e_q1 = '0;
    end else begin
      m_now = -1;
      e_gnt0 = 0; e_gnt1 = 0; e_vld0 = 0; e_vld1 = 0; e_rw = 1;
      e_all = m_just_full;
      m_just_full = 1'b0;
      if (m_prev >= 0) begin
        if (m_prev_rw == 1'b0) begin
          m_mem[m_prev_a] = m_prev_d;
          if (m_map != 8'hFF) begin
            m_map[m_prev_a] = 1'b1;
            m_just_full = (m_map == 8'hFF);
          end
        end else if (m_prev == 0) begin
          e_vld0 = 1; e_q0 = m_mem[m_prev_a];
        end else begin
          e_vld1 = 1; e_q1 = m_mem[m_prev_a];
        end
      end else begin
        el0 = req0 && (m_prev2 != 0);
        el1 = req1 && (m_prev2 != 1);
        if (el0 && el1) m_now = FIXED ? 0 : ((m_last == 0) ? 1 : 0);
        else if (el0)   m_now = 0;
        else if (el1)   m_now = 1;
        if (m_now == 0) begin
          e_gnt0 = 1; e_rw = rw0; e_a = a0; e_d = d0;
          m_prev_rw = rw0; m_prev_a = a0; m_prev_d = d0;
        end else if (m_now == 1) begin
          e_gnt1 = 1; e_rw = rw1; e_a = a1; e_d = d1;
          m_prev_rw = rw1; m_prev_a = a1; m_prev_d = d1;
        end
        if (m_now >= 0) m_last = m_now;
      end
      m_prev2 = m_prev;
      m_prev  = m_now;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    chk("gnt0",   32'(gnt0),   32'(e_gnt0));
    chk("gnt1",   32'(gnt1),   32'(e_gnt1));
    chk("vld0",   32'(vld0),   32'(e_vld0));
    chk("vld1",   32'(vld1),   32'(e_vld1));
    chk("q0",     32'(q0),     32'(e_q0));
    chk("q1",     32'(q1),     32'(e_q1));
    chk("RB_RW",  32'(RB_RW),  32'(e_rw));
    chk("RB_A",   32'(RB_A),   32'(e_a));
    chk("RB_D",   32'(RB_D),   32'(e_d));
    chk("wr_map", 32'(wr_map), 32'(m_map));
    chk("all_wr", 32'(all_wr), 32'(e_all));
    if (all_wr === 1'b1) all_cnt++;
  end

  task automatic set_req(input int p, input logic v, input logic rw,
                         input logic [2:0] a, input logic [17:0] d);
    if (p == 0) begin req0 = v; rw0 = rw; a0 = a; d0 = d; end
    else        begin req1 = v; rw1 = rw; a1 = a; d1 = d; end
  endtask

  function automatic logic got_gnt(input int p);
    return (p == 0) ? gnt0 : gnt1;
  endfunction

  // Raises req, waits (bounded) for the grant, drops req; returns in the middle of the ACC cycle.
  task automatic access(input int p, input logic rw, input logic [2:0] a, input logic [17:0] d,
                        output int gcyc, output int waited);
    int n = 0;
    set_req(p, 1'b1, rw, a, d);
    do begin
      @(negedge clk);
      n++;
    end while (!got_gnt(p) && n < 40);
    checks++;
    if (!got_gnt(p)) begin
      errors++;
      $display("FAIL grant_timeout: port%0d saw no gnt after %0d cycles, want gnt", p, n);
    end
    gcyc   = cyc;
    waited = n;
    set_req(p, 1'b0, rw, a, d);
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: bench still running at %0t, want finished", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, g1, w0, w1;
    logic [2:0] fill_a [9];
    fill_a = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    // Reset held 3 cycles with both ports requesting.
    set_req(0, 1'b1, 1'b1, 3'd0, '0);
    set_req(1, 1'b1, 1'b1, 3'd1, '0);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    chk("rst_rw",  32'(RB_RW), 32'd1);
    chk("rst_map", 32'(wr_map), 32'd0);
    chk("rst_all", 32'(all_wr), 32'd0);
    #2 rst_n = 1'b1;

    // Conflict straight out of reset: port 0 first, port 1 two cycles later.
    fork
      access(0, 1'b1, 3'd0, '0, g0, w0);
      access(1, 1'b1, 3'd1, '0, g1, w1);
    join
    @(negedge clk);
    chk("conf_gap", 32'(g1 - g0), 32'd2);
    chk("conf_q0",  32'(q0), 32'h01000);
    chk("conf_q1",  32'(q1), 32'h01001);

    // Single write from port 0, then read-back through port 1.
    access(0, 1'b0, 3'd5, 18'h2A5A5, g0, w0);
    chk("wr_latency", 32'(w0), 32'd1);
    chk("wr_bus_rw",  32'(RB_RW), 32'd0);
    chk("wr_bus_a",   32'(RB_A), 32'd5);
    chk("wr_bus_d",   32'(RB_D), 32'h2A5A5);
    @(negedge clk);
    chk("wr_map_20",  32'(wr_map), 32'h20);
    access(1, 1'b1, 3'd5, '0, g1, w1);
    @(negedge clk);
    chk("rd_back_q1", 32'(q1), 32'h2A5A5);

    // After a lone port-0 access, a fresh conflict goes to port 1 (round-robin).
    access(0, 1'b1, 3'd5, '0, g0, w0);
    repeat (2) @(negedge clk);
    fork
      access(0, 1'b1, 3'd6, '0, g0, w0);
      access(1, 1'b1, 3'd7, '0, g1, w1);
    join
    @(negedge clk);
    chk("rr_gap", 32'(FIXED ? (g1 - g0) : (g0 - g1)), 32'd2);

    // Fill the map with a duplicate write to address 3; all_wr fires once.
    all_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      access(0, 1'b0, fill_a[i], 18'(32'h20000 + i), g0, w0);
      @(negedge clk);
      if (i == 7) chk("fill_early", 32'(all_cnt), 32'd0);
    end
    repeat (3) @(negedge clk);
    chk("fill_pulses", 32'(all_cnt), 32'd1);
    chk("fill_map",    32'(wr_map), 32'hFF);

    // Reset in the middle of a write to address 2: bank keeps its old value.
    access(0, 1'b0, 3'd2, 18'h0BEEF, g0, w0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rw",   32'(RB_RW), 32'd1);
    chk("midrst_gnt0", 32'(gnt0), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    chk("midrst_map",  32'(wr_map), 32'd0);
    access(1, 1'b1, 3'd2, '0, g1, w1);
    @(negedge clk);
    chk("midrst_old",  32'(q1), 32'h20002);

    // Port 1 writes, port 0 reads the same address.
    access(1, 1'b0, 3'd4, 18'h3C3C3, g1, w1);
    @(negedge clk);
    access(0, 1'b1, 3'd4, '0, g0, w0);
    @(negedge clk);
    chk("raw_q0", 32'(q0), 32'h3C3C3);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
